// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared types, FIFO entry layout and frame sizing for camera_capture
package camera_pkg;

  localparam int PACK_DEF        = 4;
  localparam int LINE_WORDS_DEF  = 3;
  localparam int FRAME_LINES_DEF = 4;
  localparam int FIFO_DEPTH_DEF  = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_CAPTURE = CAPTURE,
    ST_DRAIN   = DRAIN
  } cap_state_e;

  // Flag bits sit directly above the packed data field in a FIFO entry.
  localparam int SOF_OFS = 0;
  localparam int EOL_OFS = 1;
  localparam int EOF_OFS = 2;
  localparam int FLAG_BITS = 3;

  function automatic int frame_bytes(input int pack, input int line_words, input int frame_lines);
    return pack * line_words * frame_lines;
  endfunction

  localparam int FRAME_BYTES = PACK_DEF * LINE_WORDS_DEF * FRAME_LINES_DEF;

endpackage

// File: rtl/camera_capture_if.sv
// rtl/camera_capture_if.sv - camera byte stream and packed-word output stream bundle
interface camera_capture_if #(
  parameter int PACK = 4
) ();

  logic              camera_en;
  logic              cam_valid;
  logic [7:0]        cam_data;
  logic              out_valid;
  logic              out_ready;
  logic [8*PACK-1:0] out_data;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;

  modport master (
    output camera_en,
    input  cam_valid,
    input  cam_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_sof,
    output out_eol,
    output out_eof
  );

  modport slave (
    input  camera_en,
    output cam_valid,
    output cam_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_sof,
    input  out_eol,
    input  out_eof
  );

endinterface

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - synchronous show-ahead FIFO, DEPTH a power of two
module capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/camera_capture.sv
// rtl/camera_capture.sv - frame capture: byte packing, line/frame tagging, output FIFO; CAMERA_CAPTURE_BYTE_SWAP_EN selects MSB-first packing
module camera_capture
  import camera_pkg::*;
#(
  parameter int PACK        = PACK_DEF,
  parameter int LINE_WORDS  = LINE_WORDS_DEF,
  parameter int FRAME_LINES = FRAME_LINES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  camera_capture_if.master bus,
  output logic             busy,
  output logic             overflow
);

  localparam int FB = frame_bytes(PACK, LINE_WORDS, FRAME_LINES);
  localparam int DW = 8 * PACK;
  localparam int EW = DW + FLAG_BITS;
  localparam int CW = $clog2(FB + 1);

`ifdef CAMERA_CAPTURE_BYTE_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic [1:0]    state;
  logic          cam_en;
  logic [CW-1:0] en_cnt;
  logic [CW-1:0] byte_cnt;
  logic [DW-1:0] word_reg;
  logic [DW-1:0] next_word;
  logic [CW-1:0] lane;
  logic [CW-1:0] word_idx;
  logic [CW-1:0] line_pos;
  logic          sample;
  logic          word_done;
  logic          last_byte;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;

  assign lane     = byte_cnt % CW'(PACK);
  assign word_idx = byte_cnt / CW'(PACK);
  assign line_pos = word_idx % CW'(LINE_WORDS);

  assign sample    = (state == CAPTURE) && bus.cam_valid;
  assign word_done = sample && (lane == CW'(PACK - 1));
  assign last_byte = sample && (byte_cnt == CW'(FB - 1));
  // Full is judged before any same-cycle pop, so a pop never makes room for this write.
  assign fifo_push = word_done && !fifo_full;
  assign fifo_pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    next_word = word_reg;
    for (int k = 0; k < PACK; k++) begin
      if (lane == CW'(k)) begin
        next_word[8*(SWAP ? (PACK-1-k) : k) +: 8] = bus.cam_data;
      end
    end
  end

  assign push_entry = {last_byte,
                       line_pos == CW'(LINE_WORDS - 1),
                       word_idx == '0,
                       next_word};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cam_en   <= 1'b0;
      en_cnt   <= '0;
      byte_cnt <= '0;
      word_reg <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPTURE;
            cam_en   <= 1'b1;
            en_cnt   <= '0;
            byte_cnt <= '0;
            word_reg <= '0;
            overflow <= 1'b0;
          end
        end
        CAPTURE: begin
          // The enable window is fixed-length; dropping it early would restart the camera.
          if (cam_en) begin
            en_cnt <= en_cnt + CW'(1);
            if (en_cnt == CW'(FB - 1)) cam_en <= 1'b0;
          end
          if (sample) begin
            word_reg <= next_word;
            byte_cnt <= byte_cnt + CW'(1);
          end
          if (word_done && fifo_full) overflow <= 1'b1;
          if (last_byte) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  capture_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.camera_en = cam_en;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = fifo_empty ? '0 : head[DW-1:0];
  assign bus.out_sof   = !fifo_empty && head[DW + SOF_OFS];
  assign bus.out_eol   = !fifo_empty && head[DW + EOL_OFS];
  assign bus.out_eof   = !fifo_empty && head[DW + EOF_OFS];
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_camera_capture.sv
// tb/tb_camera_capture.sv - directed self-checking bench for camera_capture with a camera model
module tb_camera_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic overflow;

  int errors = 0;
  int checks = 0;

  int n_words;
  int n_eof;
  int en_cycles;

  camera_capture_if #(.PACK(4)) bus ();

  camera_capture #(
    .PACK        (4),
    .LINE_WORDS  (3),
    .FRAME_LINES (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Camera stage: valid and data trail the enable by one cycle; sequence restarts when disabled.
  logic [7:0] pat [12] = '{8'hBC, 8'h27, 8'h81, 8'hFF,
                           8'hCE, 8'h1F, 8'hE0, 8'hA9,
                           8'h38, 8'h2B, 8'hD4, 8'h11};
  int cam_idx = 0;

  always @(posedge clk) begin
    bus.cam_valid <= bus.camera_en;
    if (bus.camera_en) begin
      bus.cam_data <= pat[cam_idx % 12];
      cam_idx      <= cam_idx + 1;
    end else begin
      bus.cam_data <= 8'hzz;
      cam_idx      <= 0;
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    case (i % 3)
      0:       w = 32'hFF8127BC;
      1:       w = 32'hA9E01FCE;
      default: w = 32'h11D42B38;
    endcase
`ifdef CAMERA_CAPTURE_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready high, 1: ready low, 2: ready toggles every cycle.
  task automatic collect(input int mode, input int ncyc, input bit until_idle, input int start_at);
    bit          done = 1'b0;
    bit          held = 1'b0;
    logic [31:0] held_data = '0;
    n_words   = 0;
    n_eof     = 0;
    en_cycles = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (until_idle && c > 0 && !busy) begin
        done = 1'b1;
        break;
      end
      start = (c == start_at);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = c[0];
      endcase
      if (bus.camera_en) en_cycles++;
      if (held) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_data", bus.out_data, held_data);
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        chk("word_data", bus.out_data, exp_word(n_words));
        chk("word_sof", bus.out_sof, n_words == 0);
        chk("word_eol", bus.out_eol, (n_words % 3) == 2);
        chk("word_eof", bus.out_eof, n_words == 11);
        n_words++;
        if (bus.out_eof) n_eof++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (until_idle && !done) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_camera_en", bus.camera_en, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_flags", {bus.out_sof, bus.out_eol, bus.out_eof}, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);

    // Full frame, downstream always ready.
    pulse_start();
    collect(0, 200, 1'b1, -1);
    chk("f1_en_cycles", en_cycles, 48);
    chk("f1_words", n_words, 12);
    chk("f1_eof", n_eof, 1);
    chk("f1_busy", busy, 1'b0);
    chk("f1_overflow", overflow, 1'b0);

    // Downstream stalled for the whole frame: 8 held, 4 dropped.
    pulse_start();
    collect(1, 70, 1'b0, -1);
    chk("f2_en_cycles", en_cycles, 48);
    chk("f2_overflow", overflow, 1'b1);
    chk("f2_busy_held", busy, 1'b1);
    chk("f2_head_valid", bus.out_valid, 1'b1);
    chk("f2_head_data", bus.out_data, exp_word(0));
    chk("f2_head_sof", bus.out_sof, 1'b1);
    collect(0, 40, 1'b1, -1);
    chk("f2_words", n_words, 8);
    chk("f2_eof", n_eof, 0);
    chk("f2_busy", busy, 1'b0);
    chk("f2_overflow_sticky", overflow, 1'b1);

    // Ready toggling every cycle.
    pulse_start();
    chk("f3_overflow_cleared", overflow, 1'b0);
    collect(2, 300, 1'b1, -1);
    chk("f3_words", n_words, 12);
    chk("f3_eof", n_eof, 1);
    chk("f3_overflow", overflow, 1'b0);

    // Reset during the 20th enable cycle.
    pulse_start();
    bus.out_ready = 1'b1;
    begin
      int seen = 1;
      bit hit = 1'b0;
      for (int c = 0; c < 60; c++) begin
        if (seen == 20 && bus.camera_en) begin
          hit = 1'b1;
          break;
        end
        @(negedge clk);
        if (bus.camera_en) seen++;
      end
      chk("f4_reached_20", hit, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("f4_camera_en", bus.camera_en, 1'b0);
    chk("f4_out_valid", bus.out_valid, 1'b0);
    chk("f4_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start();
    collect(0, 200, 1'b1, -1);
    chk("f4_words", n_words, 12);
    chk("f4_en_cycles", en_cycles, 48);

    // Start pulsed mid-capture must be ignored.
    pulse_start();
    collect(0, 200, 1'b1, 10);
    chk("f5_words", n_words, 12);
    chk("f5_eof", n_eof, 1);
    chk("f5_en_cycles", en_cycles, 48);
    chk("f5_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/camera_capture.md
Name: camera_capture

Overview:
- Sits directly downstream of the camera stage: drives `camera_en` and consumes its `data_valid`/`data_out` byte stream.
- Packs PACK bytes into one word and tags each word with line/frame markers.
- Buffers words in a small synchronous FIFO and presents them to the next stage on a valid/ready handshake.
- One capture is one frame of FRAME_BYTES = PACK*LINE_WORDS*FRAME_LINES bytes, started by a `start` pulse.

Parameters:
- PACK, 4: bytes per output word.
- LINE_WORDS, 3: words per line.
- FRAME_LINES, 4: lines per frame.
- FIFO_DEPTH, 8: FIFO entries, power of 2, minimum 2.

Ports:
- clk, input, 1: clock, all logic on rising edge.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: pulse, begins a frame capture when idle.
- camera_en, output, 1: enable to camera stage.
- cam_valid, input, 1: camera data_valid.
- cam_data, input, 8: camera data_out; may be Z when cam_valid=0.
- out_valid, output, 1: word available.
- out_ready, input, 1: downstream accepts word.
- out_data, output, 8*PACK: packed word.
- out_sof, output, 1: word is first of frame.
- out_eol, output, 1: word is last of a line.
- out_eof, output, 1: word is last of frame.
- busy, output, 1: state != IDLE.
- overflow, output, 1: sticky, a word was dropped on FIFO full.

Behaviour:
- Reset values: camera_en=0, out_valid=0, out_data=0, all flags 0, busy=0, overflow=0. FIFO emptied, all counters 0, state IDLE. Reset mid-capture aborts immediately; the partial word is discarded.
- FSM has three states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 moves to CAPTURE, clears `overflow`, clears the enable-cycle and byte counters.
  - camera_en (registered) goes 1 in the first CAPTURE cycle.
- CAPTURE (enable timing):
  - camera_en stays high for exactly FRAME_BYTES consecutive cycles, then drops to 0.
  - camera_en is never toggled mid-frame, because the camera restarts its sequence when disabled.
- CAPTURE (byte sampling):
  - Bytes are sampled only when cam_valid=1 (cam_valid trails camera_en by 1 cycle).
  - Byte k of a word goes to out_data[8k+7:8k], so the first byte is the LSB.
  - Byte counter runs 0..FRAME_BYTES-1; word and line counters are derived from it.
- CAPTURE to DRAIN: after the FRAME_BYTES-th byte is sampled.
- DRAIN: waits until the FIFO is empty, then goes to IDLE.
- `start` while busy is ignored.
- Word completion:
  - On the edge sampling the last byte of a word, {eof, eol, sof, data} is written to the FIFO.
  - sof = first word of frame; eol = word index mod LINE_WORDS == LINE_WORDS-1; eof = last word.
  - Latency: out_valid can be 1 in the cycle after that edge.
- Overflow: if the FIFO is full on a word write, the word is dropped and `overflow` is set. A simultaneous pop in the same cycle does not free space for that write. Byte counting continues, so frame length stays fixed.
- FIFO:
  - Show-ahead: out_data/flags reflect the head entry whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - Simultaneous push and pop when not full is legal; count is unchanged.
  - Head is held stable while out_ready=0.
- cam_valid=1 outside CAPTURE is ignored.

Optional Feature:
- Macro CAMERA_CAPTURE_BYTE_SWAP_EN.
- Defined: big-endian packing; the first byte goes to the MSB (out_data[8*PACK-1 : 8*PACK-8]).
- Undefined: LSB-first packing as above.
- Flags and timing are identical in both cases.

Decomposition:
- Package camera_pkg:
  - state enum (IDLE/CAPTURE/DRAIN);
  - FIFO entry flag bit positions (SOF/EOL/EOF offsets above the data field);
  - localparam FRAME_BYTES formula.
- One sub-module capture_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, ports push/pop/full/empty.

Test Plan:
- Reset, then `start` with out_ready=1 and the camera model attached (PACK=4, LINE_WORDS=3, FRAME_LINES=4):
  - camera_en is high for exactly 48 cycles.
  - Words arrive in order: 0xFF8127BC (sof=1), 0xA9E01FCE, 0x11D42B38 (eol=1), repeating.
  - 12th word has eol=1 and eof=1; busy returns to 0; overflow=0.
- Same as above with CAMERA_CAPTURE_BYTE_SWAP_EN defined:
  - first word is 0xBC2781FF, third is 0x382BD411.
- out_ready=0 for the whole frame, FIFO_DEPTH=8:
  - first 8 words are held, 4 are dropped, overflow=1.
  - Releasing out_ready yields 8 words, the first 0xFF8127BC with sof=1; busy then drops.
- out_ready toggling 1/0 every cycle:
  - all 12 words delivered, none lost or duplicated.
  - out_data is stable while out_valid=1 & out_ready=0.
- Assert rst for one cycle during the 20th enable cycle:
  - next cycle camera_en=0, out_valid=0, busy=0.
  - A new `start` produces a clean frame starting at 0xFF8127BC.
- `start` pulsed during CAPTURE: ignored; still exactly 12 words and one eof.
